// File: rtl/ft245_sync_bus_arbiter_if.sv
// Signal bundle between the FT245 sync-FIFO pins / RX-TX datapaths and the
// bus arbiter. The arbiter side uses the master modport; whatever drives the
// FIFO flags and datapath handshakes uses the slave modport.
interface ft245_sync_bus_arbiter_if;
    // FT245 FIFO status flags (active low)
    logic ft245_rxfn;
    logic ft245_txen;
    // Datapath handshakes
    logic rx_ready;
    logic tx_valid;
    // FT245 strobes (active low)
    logic ft245_oen;
    logic ft245_rdn;
    logic ft245_wrn;
    // Beat qualifiers and ownership status
    logic rd_beat;
    logic wr_beat;
    logic rd_grant;
    logic wr_grant;
    logic busy;

    modport master (
        input  ft245_rxfn, ft245_txen, rx_ready, tx_valid,
        output ft245_oen, ft245_rdn, ft245_wrn,
        output rd_beat, wr_beat, rd_grant, wr_grant, busy
    );

    modport slave (
        output ft245_rxfn, ft245_txen, rx_ready, tx_valid,
        input  ft245_oen, ft245_rdn, ft245_wrn,
        input  rd_beat, wr_beat, rd_grant, wr_grant, busy
    );
endinterface

// File: rtl/ft245_sync_bus_arbiter.sv
// Half-duplex FT245 sync-FIFO bus arbiter. Grants the shared data bus to
// either the read (RX) or write (TX) direction, drives OE#/RD#/WR#, inserts a
// bus turnaround after every burst and round-robins between directions when
// both want the bus. Bursts are capped at MAX_BURST beats.
module ft245_sync_bus_arbiter #(
    parameter int MAX_BURST   = 256,
    parameter int TURN_CYCLES = 1
) (
    input  logic                            ft245_dclk,
    input  logic                            rstn,
    ft245_sync_bus_arbiter_if.master        bus
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam int TCW = $clog2(TURN_CYCLES + 1);

    localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BURST - 1);
    localparam logic [BCW-1:0] BEAT_MAX  = BCW'(MAX_BURST);
    localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_OE,
        ST_RD_BURST,
        ST_WR_BURST,
        ST_TURN
    } state_e;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;

    state_e         state_q,    state_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic [TCW-1:0] turn_cnt_q, turn_cnt_d;
    dir_e           last_dir_q, last_dir_d;
    logic           oen_q,      oen_d;
    logic           rdn_q,      rdn_d;

    logic           rd_req;
    logic           wr_req;
    logic           rd_beat_c;
    logic           wr_beat_c;
    logic           wrn_c;
    logic [BCW-1:0] beat_cnt_inc;

    assign rd_req = ~bus.ft245_rxfn & bus.rx_ready;
    assign wr_req = ~bus.ft245_txen & bus.tx_valid;

    // Beat counter never wraps: it holds at MAX_BURST.
    assign beat_cnt_inc = (beat_cnt_q == BEAT_MAX) ? beat_cnt_q : beat_cnt_q + BCW'(1);

    // State register and registered strobes; reset releases the bus at once.
    always_ff @(posedge ft245_dclk) begin
        // NOTE: reset is sampled synchronously here, and all state uses
        // non-blocking assignments so every flop sees pre-edge values.
        if (!rstn) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            turn_cnt_q <= '0;
            last_dir_q <= DIR_WR;
            oen_q      <= 1'b1;
            rdn_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            last_dir_q <= last_dir_d;
            oen_q      <= oen_d;
            rdn_q      <= rdn_d;
        end
    end

    // Next-state, counter and strobe decisions for the bus sequencer.
    always_comb begin
        // NOTE: every signal written below gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        turn_cnt_d = turn_cnt_q;
        last_dir_d = last_dir_q;
        oen_d      = oen_q;
        rdn_d      = rdn_q;
        rd_beat_c  = 1'b0;
        wr_beat_c  = 1'b0;
        wrn_c      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // On a tie the direction not served last wins.
                if (rd_req && (!wr_req || last_dir_q == DIR_WR)) begin
                    state_d    = ST_RD_OE;
                    beat_cnt_d = '0;
                    last_dir_d = DIR_RD;
                    oen_d      = 1'b0;
                end else if (wr_req) begin
                    state_d    = ST_WR_BURST;
                    beat_cnt_d = '0;
                    last_dir_d = DIR_WR;
                end
            end

            ST_RD_OE: begin
                // The FT245 takes the bus during this cycle; start reading next.
                state_d = ST_RD_BURST;
                rdn_d   = 1'b0;
            end

            ST_RD_BURST: begin
                rd_beat_c = ~rdn_q & ~bus.ft245_rxfn & bus.rx_ready;
                if (rd_beat_c) begin
                    beat_cnt_d = beat_cnt_inc;
                end
                if (bus.ft245_rxfn || !bus.rx_ready ||
                    (rd_beat_c && beat_cnt_q == BEAT_LAST)) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                    rdn_d      = 1'b1;
                    oen_d      = 1'b1;
                end
            end

            ST_WR_BURST: begin
                // WR# follows the beat combinationally; the exiting beat still goes out.
                wr_beat_c = bus.tx_valid & ~bus.ft245_txen;
                wrn_c     = ~wr_beat_c;
                if (wr_beat_c) begin
                    beat_cnt_d = beat_cnt_inc;
                end
                if (bus.ft245_txen || !bus.tx_valid ||
                    (wr_beat_c && beat_cnt_q == BEAT_LAST)) begin
                    state_d    = ST_TURN;
                    turn_cnt_d = '0;
                end
            end

            ST_TURN: begin
                // Bus idles with OE# high; requests are not looked at here.
                if (turn_cnt_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + TCW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                oen_d   = 1'b1;
                rdn_d   = 1'b1;
            end
        endcase
    end

    assign bus.ft245_oen = oen_q;
    assign bus.ft245_rdn = rdn_q;
    assign bus.ft245_wrn = wrn_c;
    assign bus.rd_beat   = rd_beat_c;
    assign bus.wr_beat   = wr_beat_c;
    assign bus.rd_grant  = (state_q == ST_RD_OE) || (state_q == ST_RD_BURST);
    assign bus.wr_grant  = (state_q == ST_WR_BURST);
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ft245_sync_bus_arbiter.sv
// Bench for ft245_sync_bus_arbiter. Three instances with different burst and
// turnaround settings share the same stimulus; a transaction-level model
// predicts each instance's outputs per cycle into a queue, and a monitor on
// the falling edge pops and compares.
module tb_ft245_sync_bus_arbiter;

    localparam int N_INST = 3;

    typedef struct packed {
        logic oen;
        logic rdn;
        logic wrn;
        logic rd_beat;
        logic wr_beat;
        logic rd_grant;
        logic wr_grant;
        logic busy;
    } outs_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    ft245_sync_bus_arbiter_if bus0 ();
    ft245_sync_bus_arbiter_if bus1 ();
    ft245_sync_bus_arbiter_if bus2 ();

    ft245_sync_bus_arbiter #(.MAX_BURST(256), .TURN_CYCLES(1)) u_dut0 (
        .ft245_dclk (clk),
        .rstn       (rstn),
        .bus        (bus0)
    );
    ft245_sync_bus_arbiter #(.MAX_BURST(4), .TURN_CYCLES(1)) u_dut1 (
        .ft245_dclk (clk),
        .rstn       (rstn),
        .bus        (bus1)
    );
    ft245_sync_bus_arbiter #(.MAX_BURST(1), .TURN_CYCLES(3)) u_dut2 (
        .ft245_dclk (clk),
        .rstn       (rstn),
        .bus        (bus2)
    );

    function automatic int mb_of(input int k);
        case (k)
            0:       return 256;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int tc_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    // Observed outputs per instance
    outs_t obs [N_INST];
    assign obs[0] = {bus0.ft245_oen, bus0.ft245_rdn, bus0.ft245_wrn, bus0.rd_beat,
                     bus0.wr_beat, bus0.rd_grant, bus0.wr_grant, bus0.busy};
    assign obs[1] = {bus1.ft245_oen, bus1.ft245_rdn, bus1.ft245_wrn, bus1.rd_beat,
                     bus1.wr_beat, bus1.rd_grant, bus1.wr_grant, bus1.busy};
    assign obs[2] = {bus2.ft245_oen, bus2.ft245_rdn, bus2.ft245_wrn, bus2.rd_beat,
                     bus2.wr_beat, bus2.rd_grant, bus2.wr_grant, bus2.busy};

    // Scoreboard
    outs_t exp_q [N_INST][$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    obs_rd [N_INST];
    int    obs_wr [N_INST];

    // Reference model: who owns the bus and how far along it is
    bit m_rd_owner   [N_INST];
    bit m_wr_owner   [N_INST];
    bit m_oe_pending [N_INST];
    int m_turn_left  [N_INST];
    int m_beats      [N_INST];
    bit m_last_wr    [N_INST];

    task automatic check(input string name, input int k, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h", name, k, $time, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_rd_owner[k]   = 1'b0;
        m_wr_owner[k]   = 1'b0;
        m_oe_pending[k] = 1'b0;
        m_turn_left[k]  = 0;
        m_beats[k]      = 0;
        m_last_wr[k]    = 1'b1;
    endtask

    function automatic outs_t predict(input int k, input bit rxfn, input bit txen,
                                      input bit rr, input bit tv);
        outs_t o;
        o = '0;
        o.oen = 1'b1;
        o.rdn = 1'b1;
        o.wrn = 1'b1;
        if (m_rd_owner[k]) begin
            o.busy     = 1'b1;
            o.rd_grant = 1'b1;
            o.oen      = 1'b0;
            if (!m_oe_pending[k]) begin
                o.rdn     = 1'b0;
                o.rd_beat = !rxfn && rr;
            end
        end else if (m_wr_owner[k]) begin
            o.busy     = 1'b1;
            o.wr_grant = 1'b1;
            o.wr_beat  = tv && !txen;
            o.wrn      = !(tv && !txen);
        end else if (m_turn_left[k] > 0) begin
            o.busy = 1'b1;
        end
        return o;
    endfunction

    task automatic model_step(input int k, input bit r, input bit rxfn, input bit txen,
                              input bit rr, input bit tv);
        bit beat;
        if (!r) begin
            model_reset(k);
        end else if (m_rd_owner[k]) begin
            if (m_oe_pending[k]) begin
                m_oe_pending[k] = 1'b0;
            end else begin
                beat = !rxfn && rr;
                if (beat) m_beats[k]++;
                if (rxfn || !rr || (beat && m_beats[k] == mb_of(k))) begin
                    m_rd_owner[k]  = 1'b0;
                    m_turn_left[k] = tc_of(k);
                end
            end
        end else if (m_wr_owner[k]) begin
            beat = tv && !txen;
            if (beat) m_beats[k]++;
            if (txen || !tv || (beat && m_beats[k] == mb_of(k))) begin
                m_wr_owner[k]  = 1'b0;
                m_turn_left[k] = tc_of(k);
            end
        end else if (m_turn_left[k] > 0) begin
            m_turn_left[k]--;
        end else begin
            if (!rxfn && rr && (!(!txen && tv) || m_last_wr[k])) begin
                m_rd_owner[k]   = 1'b1;
                m_oe_pending[k] = 1'b1;
                m_beats[k]      = 0;
                m_last_wr[k]    = 1'b0;
            end else if (!txen && tv) begin
                m_wr_owner[k] = 1'b1;
                m_beats[k]    = 0;
                m_last_wr[k]  = 1'b1;
            end
        end
    endtask

    // One clock cycle of stimulus: drive, predict, advance the model.
    task automatic cycle(input bit r, input bit rxfn, input bit txen,
                         input bit rr, input bit tv);
        @(posedge clk);
        #1;
        rstn = r;
        bus0.ft245_rxfn = rxfn; bus0.ft245_txen = txen; bus0.rx_ready = rr; bus0.tx_valid = tv;
        bus1.ft245_rxfn = rxfn; bus1.ft245_txen = txen; bus1.rx_ready = rr; bus1.tx_valid = tv;
        bus2.ft245_rxfn = rxfn; bus2.ft245_txen = txen; bus2.rx_ready = rr; bus2.tx_valid = tv;
        for (int k = 0; k < N_INST; k++) begin
            exp_q[k].push_back(predict(k, rxfn, txen, rr, tv));
            model_step(k, r, rxfn, txen, rr, tv);
        end
    endtask

    task automatic cycles(input int n, input bit r, input bit rxfn, input bit txen,
                          input bit rr, input bit tv);
        for (int i = 0; i < n; i++) cycle(r, rxfn, txen, rr, tv);
    endtask

    // Wait until the monitor has consumed the last driven cycle.
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the model's prediction.
    int mon_cyc   = 0;
    int last_beat2 = -1;
    always @(negedge clk) begin
        outs_t e;
        outs_t a;
        for (int k = 0; k < N_INST; k++) begin
            if (exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                a = obs[k];
                check("outputs{oen,rdn,wrn,rdb,wrb,rg,wg,busy}", k, 32'(a), 32'(e));
                check("grant exclusive", k, 32'(a.rd_grant & a.wr_grant), 32'd0);
                check("no write beat with oen low", k, 32'(~a.oen & a.wr_beat), 32'd0);
                check("rdn low implies oen low", k, 32'(~a.rdn & a.oen), 32'd0);
                if (a.rd_beat) obs_rd[k]++;
                if (a.wr_beat) obs_wr[k]++;
                if (k == 2 && (a.rd_beat || a.wr_beat)) begin
                    if (last_beat2 >= 0)
                        check("single-beat spacing >= 5", 2, 32'(mon_cyc - last_beat2 >= 5), 32'd1);
                    last_beat2 = mon_cyc;
                end
            end
        end
        if (!rstn) last_beat2 = -1;
        mon_cyc++;
    end

    int snap_rd;
    int snap_wr;

    initial begin
        rstn = 1'b0;
        bus0.ft245_rxfn = 1'b1; bus0.ft245_txen = 1'b1; bus0.rx_ready = 1'b0; bus0.tx_valid = 1'b0;
        bus1.ft245_rxfn = 1'b1; bus1.ft245_txen = 1'b1; bus1.rx_ready = 1'b0; bus1.tx_valid = 1'b0;
        bus2.ft245_rxfn = 1'b1; bus2.ft245_txen = 1'b1; bus2.rx_ready = 1'b0; bus2.tx_valid = 1'b0;
        for (int k = 0; k < N_INST; k++) begin
            model_reset(k);
            obs_rd[k] = 0;
            obs_wr[k] = 0;
        end

        // Reset held with both FIFOs requesting: bus must stay released.
        cycles(5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Plain read burst: 10 beats, then RX FIFO empties.
        settle();
        snap_rd = obs_rd[0];
        cycles(12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        check("read burst beat count", 0, 32'(obs_rd[0] - snap_rd), 32'd10);

        // Round robin from reset with both directions always requesting.
        cycles(2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        snap_rd = obs_rd[1];
        snap_wr = obs_wr[1];
        cycles(26, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("round robin read beats", 1, 32'(obs_rd[1] - snap_rd), 32'd8);
        check("round robin write beats", 1, 32'(obs_wr[1] - snap_wr), 32'd8);

        // Back-pressure: tx_valid gap mid-write, then rx_ready gap mid-read.
        cycles(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycles(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycles(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycles(6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset during the third read beat, then a fresh read.
        cycles(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycles(4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Single-beat bursts with a 3-cycle turnaround: one write every 5 cycles.
        cycles(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        snap_wr = obs_wr[2];
        cycles(20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        check("single-beat write cadence", 2, 32'(obs_wr[2] - snap_wr), 32'd4);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 299) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 5) != 0,
                  $urandom_range(0, 5) != 0);
        end

        settle();
        for (int k = 0; k < N_INST; k++) begin
            check("expected queue drained", k, 32'(exp_q[k].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
